// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and
// data access. Data has priority. After STARVE_LIMIT data grants made while
// a fetch waits, the waiting fetch wins the next arbitration.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req/i_addr/i_flush        fetch request, PC, redirect (drops result)
//   i_ack/i_rdata               fetch completion and instruction
//   d_re/d_we/d_addr/d_wdata    load/store request (store wins if both)
//   d_ack/d_rdata               data completion and load data
//   mem_req/mem_we/mem_addr/mem_wdata   registered memory request
//   mem_ready/mem_rdata         memory completion and read data
//   if_stall, mem_stall         pipeline freeze signals
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_flush,
   output logic                  i_ack,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_re,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_ack,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  if_stall,
   output logic                  mem_stall
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DATA  = 2'd1;
   localparam logic [1:0] FETCH = 2'd2;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   logic [1:0] state;
   logic [2:0] starve;
   logic       drop;
   logic       d_req;
   logic       grant_d;
   logic       grant_i;
   logic       done;

   always_comb begin
      d_req   = d_re | d_we;
      // A fetch waiting through LIMIT data grants takes the next slot.
      grant_d = (state == IDLE) && d_req && ((starve < LIMIT) || !i_req);
      grant_i = (state == IDLE) && !grant_d && i_req;
      done    = (state != IDLE) && mem_ready;
      d_ack   = done && (state == DATA);
      // A flush in the completion cycle cancels the result just like an
      // earlier flush that set the drop flag.
      i_ack   = done && (state == FETCH) && !drop && !i_flush;
      i_rdata = mem_rdata;
      d_rdata = mem_rdata;
      if_stall  = i_req & ~i_ack;
      mem_stall = d_req & ~d_ack;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         starve    <= '0;
         drop      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state     <= DATA;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  // grant_d with i_req set implies starve < LIMIT, so the
                  // increment saturates naturally at LIMIT.
                  starve    <= i_req ? starve + 3'd1 : '0;
               end else if (grant_i) begin
                  state    <= FETCH;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= i_addr;
                  starve   <= '0;
               end else if (!i_req) begin
                  starve <= '0;
               end
            end
            DATA: begin
               if (mem_ready) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
            end
            FETCH: begin
               if (mem_ready) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  drop    <= 1'b0;
               end else if (i_flush) begin
                  drop <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               drop    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, i_flush, i_ack;
   logic [31:0] i_addr, i_rdata;
   logic        d_re, d_we, d_ack;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        if_stall, mem_stall;

   int tests = 0;
   int fails = 0;

   logic [31:0] mem_model [logic [31:0]];

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
      .i_ack(i_ack), .i_rdata(i_rdata),
      .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .if_stall(if_stall), .mem_stall(mem_stall)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      i_req = 0; i_addr = 0; i_flush = 0;
      d_re = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      mem_ready = 0; mem_rdata = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if ({mem_req, mem_we, i_ack, d_ack} !== 4'b0000 || mem_addr !== 32'h0 ||
          mem_wdata !== 32'h0) begin
         fails++;
         $display("FAIL reset: req=%b we=%b iack=%b dack=%b addr=%h wdata=%h, required all 0",
                  mem_req, mem_we, i_ack, d_ack, mem_addr, mem_wdata);
      end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_single_fetch();
      @(negedge clk);
      i_req = 1; i_addr = 32'h40;
      @(negedge clk);
      mem_ready = 1; mem_rdata = 32'h1234_5678;
      #1;
      tests++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
         fails++;
         $display("FAIL fetch_issue: req=%b we=%b addr=%h, required 1 0 00000040",
                  mem_req, mem_we, mem_addr);
      end
      tests++;
      if (i_ack !== 1'b1 || i_rdata !== 32'h1234_5678 || if_stall !== 1'b0 || d_ack !== 1'b0) begin
         fails++;
         $display("FAIL fetch_ack: iack=%b rdata=%h stall=%b dack=%b, required 1 12345678 0 0",
                  i_ack, i_rdata, if_stall, d_ack);
      end
      @(negedge clk);
      i_req = 0; mem_ready = 0;
      #1;
      tests++;
      if (mem_req !== 1'b0 || if_stall !== 1'b0) begin
         fails++;
         $display("FAIL fetch_after: req=%b stall=%b, required 0 0", mem_req, if_stall);
      end
   endtask

   task automatic test_store_priority();
      @(negedge clk);
      d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
      i_req = 1; i_addr = 32'h44;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         mem_ready = (c == 3);
         mem_rdata = 32'hFFFF_0000;
         #1;
         tests++;
         if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 ||
             mem_wdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL store_issue c%0d: req=%b we=%b addr=%h wdata=%h, required 1 1 00000100 deadbeef",
                     c, mem_req, mem_we, mem_addr, mem_wdata);
         end
         tests++;
         if (d_ack !== (c == 3) || i_ack !== 1'b0 || mem_stall !== (c != 3) || if_stall !== 1'b1) begin
            fails++;
            $display("FAIL store_ack c%0d: dack=%b iack=%b mstall=%b istall=%b, required %b 0 %b 1",
                     c, d_ack, i_ack, mem_stall, if_stall, c == 3, c != 3);
         end
      end
      @(negedge clk);
      d_we = 0; mem_ready = 0;
      @(negedge clk);
      mem_ready = 1; mem_rdata = 32'hCAFE_0044;
      #1;
      tests++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h44 ||
          i_ack !== 1'b1 || i_rdata !== 32'hCAFE_0044) begin
         fails++;
         $display("FAIL store_then_fetch: req=%b we=%b addr=%h iack=%b rdata=%h, required 1 0 00000044 1 cafe0044",
                  mem_req, mem_we, mem_addr, i_ack, i_rdata);
      end
      @(negedge clk);
      i_req = 0; mem_ready = 0;
   endtask

   task automatic test_starvation();
      string got, want;
      int grants;
      got = ""; want = "DDDDFDDDDF"; grants = 0;
      @(negedge clk);
      d_re = 1; d_addr = 32'h8; i_req = 1; i_addr = 32'hC;
      mem_ready = 1; mem_rdata = 32'h0;
      for (int c = 0; c < 40 && grants < 10; c++) begin
         @(negedge clk);
         #1;
         if (d_ack === 1'b1) begin got = {got, "D"}; grants++; end
         else if (i_ack === 1'b1) begin got = {got, "F"}; grants++; end
      end
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL starve_order: got %s, required %s", got, want);
      end
      @(negedge clk);
      d_re = 0; i_req = 0; mem_ready = 0;
      @(negedge clk);
   endtask

   task automatic test_flush();
      @(negedge clk);
      i_req = 1; i_addr = 32'h80;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         i_flush = (c == 1);
         if (c == 1) i_addr = 32'h200;
         mem_ready = (c == 4); mem_rdata = 32'hBAD0_0080;
         #1;
         tests++;
         if (i_ack !== 1'b0 || mem_addr !== 32'h80) begin
            fails++;
            $display("FAIL flush_drop c%0d: iack=%b addr=%h, required 0 00000080", c, i_ack, mem_addr);
         end
      end
      @(negedge clk);
      i_flush = 0; mem_ready = 0;
      @(negedge clk);
      mem_ready = 1; mem_rdata = 32'h600D_0200;
      #1;
      tests++;
      if (mem_addr !== 32'h200 || i_ack !== 1'b1 || i_rdata !== 32'h600D_0200) begin
         fails++;
         $display("FAIL flush_refetch: addr=%h iack=%b rdata=%h, required 00000200 1 600d0200",
                  mem_addr, i_ack, i_rdata);
      end
      // flush arriving in the completion cycle itself
      @(negedge clk);
      i_addr = 32'h300; mem_ready = 0;
      @(negedge clk);
      mem_ready = 1; i_flush = 1; i_addr = 32'h304;
      #1;
      tests++;
      if (i_ack !== 1'b0) begin
         fails++;
         $display("FAIL flush_same_cycle: iack=%b, required 0", i_ack);
      end
      @(negedge clk);
      i_flush = 0; mem_ready = 0;
      @(negedge clk);
      mem_ready = 1; mem_rdata = 32'h0000_0304;
      #1;
      tests++;
      if (mem_addr !== 32'h304 || i_ack !== 1'b1) begin
         fails++;
         $display("FAIL flush_same_refetch: addr=%h iack=%b, required 00000304 1", mem_addr, i_ack);
      end
      @(negedge clk);
      i_req = 0; mem_ready = 0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      d_re = 1; d_addr = 32'h20;
      @(negedge clk);
      rst_n = 0; mem_ready = 1;
      #1;
      tests++;
      if (mem_req !== 1'b0 || d_ack !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: req=%b dack=%b, required 0 0", mem_req, d_ack);
      end
      @(negedge clk);
      d_re = 0; mem_ready = 0; rst_n = 1;
      @(negedge clk);
      d_re = 1; d_addr = 32'h10;
      @(negedge clk);
      mem_ready = 1; mem_rdata = 32'h0000_0A10;
      #1;
      tests++;
      if (mem_addr !== 32'h10 || mem_we !== 1'b0 || d_ack !== 1'b1 || d_rdata !== 32'h0000_0A10) begin
         fails++;
         $display("FAIL reset_reload: addr=%h we=%b dack=%b rdata=%h, required 00000010 0 1 00000a10",
                  mem_addr, mem_we, d_ack, d_rdata);
      end
      @(negedge clk);
      d_re = 0; mem_ready = 0;
   endtask

   // Reference model: each idle cycle picks the owner of the next transfer
   // from the pending requests and a count of data grants a waiting fetch
   // has endured; the following cycle must show that transfer on the bus.
   task automatic test_random(input int ncyc, input int pct);
      int lat, wcnt, exp_kind, owner, cnt, c;
      logic new_grant, i_done, d_done, rdy, exp_i, exp_d;
      logic [31:0] e_addr, e_wdata, rv;
      logic e_we;
      lat = 0; wcnt = 0; exp_kind = 0; owner = 0; cnt = 0; c = 0;
      new_grant = 0; i_done = 0; d_done = 0; e_addr = 0; e_wdata = 0; e_we = 0;
      forever begin
         @(negedge clk);
         tests++;
         if (exp_kind == 0) begin
            if (mem_req !== 1'b0) begin
               fails++;
               $display("FAIL rnd_idle cyc%0d: mem_req=%b, required 0", c, mem_req);
            end
         end else if (mem_req !== 1'b1 || mem_we !== e_we || mem_addr !== e_addr ||
                      (e_we && mem_wdata !== e_wdata)) begin
            fails++;
            $display("FAIL rnd_bus cyc%0d: req=%b we=%b addr=%h wdata=%h, required 1 %b %h %h",
                     c, mem_req, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
         end
         if (new_grant) begin lat = $urandom_range(0, 3); wcnt = 0; end
         if (c >= ncyc + 300) begin
            fails++;
            $display("FAIL rnd_drain: not idle after %0d cycles", c);
            break;
         end
         if (c >= ncyc && !i_req && !d_re && !d_we && exp_kind == 0 && !i_done && !d_done) break;
         // requesters
         if (i_done) begin i_req = 0; i_done = 0; end
         if (d_done) begin d_re = 0; d_we = 0; d_done = 0; end
         if (c < ncyc && !i_req && $urandom_range(0, 99) < pct) begin
            i_req = 1; i_addr = {$urandom_range(0, 255), 2'b00};
         end
         if (c < ncyc && !d_re && !d_we && $urandom_range(0, 99) < pct) begin
            case ($urandom_range(0, 2))
               0: d_re = 1;
               1: d_we = 1;
               default: begin d_re = 1; d_we = 1; end
            endcase
            d_addr = {$urandom_range(0, 15), 2'b00}; d_wdata = $urandom;
         end
         // memory
         rv = $urandom;
         if (exp_kind != 0) begin
            rdy = (wcnt == lat); wcnt++;
            if (owner == 1 && !e_we && mem_model.exists(e_addr)) rv = mem_model[e_addr];
         end else begin
            rdy = 1'($urandom_range(0, 1));
         end
         mem_ready = rdy; mem_rdata = rv;
         #1;
         exp_d = (exp_kind == 1) && rdy;
         exp_i = (exp_kind == 2) && rdy;
         tests++;
         if (d_ack !== exp_d || i_ack !== exp_i || (exp_d && d_rdata !== rv) || (exp_i && i_rdata !== rv) ||
             if_stall !== (i_req & ~exp_i) || mem_stall !== ((d_re | d_we) & ~exp_d)) begin
            fails++;
            $display("FAIL rnd_ack cyc%0d: dack=%b iack=%b istall=%b mstall=%b, required %b %b %b %b",
                     c, d_ack, i_ack, if_stall, mem_stall, exp_d, exp_i,
                     i_req & ~exp_i, (d_re | d_we) & ~exp_d);
         end
         if (exp_d) begin d_done = 1; if (e_we) mem_model[e_addr] = e_wdata; end
         if (exp_i) i_done = 1;
         // next cycle expectation
         new_grant = 0;
         if (exp_kind != 0) begin
            if (rdy) exp_kind = 0;
         end else if ((d_re || d_we) && (cnt < LIMIT || !i_req)) begin
            exp_kind = 1; owner = 1; new_grant = 1;
            e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
            cnt = i_req ? cnt + 1 : 0;
         end else if (i_req) begin
            exp_kind = 2; owner = 2; new_grant = 1;
            e_we = 0; e_addr = i_addr; cnt = 0;
         end else begin
            cnt = 0;
         end
         c++;
      end
      mem_ready = 0;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_store_priority();
      test_starvation();
      test_flush();
      test_reset_mid();
      test_random(600, 40);
      test_random(300, 100);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
